// File: rtl/bit4_pkg.sv
// Shared constants and FSM state type for the bit4_expand thermometer serializer.
package bit4_pkg;

  localparam int unsigned WORD_W  = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned MAX_CNT = 4;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bit4_expand_if.sv
// Request/serial-output bundle for bit4_expand; master drives requests, slave is the expander.
interface bit4_expand_if;
  import bit4_pkg::*;

  logic              in_valid;
  logic [CNT_W-1:0]  in_count;
  logic              in_ready;
  logic [WORD_W-1:0] word;
  logic              out_valid;
  logic              out_bit;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, word, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, word, out_valid, out_bit, out_last
  );

endinterface

// File: rtl/bit4_therm.sv
// Saturating count-to-thermometer converter: bit i is set when i < count.
module bit4_therm
  import bit4_pkg::*;
(
  input  logic [CNT_W-1:0]  count,
  output logic [WORD_W-1:0] therm
);

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      therm[i] = (32'(count) > i);
    end
  end

endmodule

// File: rtl/bit4_expand.sv
// Accepts a 0..4 count, loads its thermometer word and shifts it out LSB first over 4 handshakes.
// Optional sticky illegal-count flag `err` is built only when BIT4_EXPAND_ERR_EN is defined.
module bit4_expand
  import bit4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  bit4_expand_if.slave bus
`ifdef BIT4_EXPAND_ERR_EN
  ,
  output logic       err
`endif
);

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] therm;
  logic              in_ready;
  logic              out_valid;
  logic              out_bit;
  logic              out_last;

  bit4_therm u_therm (
    .count (bus.in_count),
    .therm (therm)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          word_d  = therm;
          idx_d   = 2'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = word_q[idx_q];
        out_last  = (idx_q == 2'd3);
        if (bus.out_ready) begin
          idx_d = idx_q + 2'd1;
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

`ifdef BIT4_EXPAND_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (bus.in_valid && in_ready && (bus.in_count > CNT_W'(MAX_CNT))) begin
      err <= 1'b1;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.word      = word_q;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_bit4_expand.sv
// Scoreboard bench for bit4_expand: stimulus pushes expected serial bits, a monitor pops and compares.
module tb_bit4_expand;
  import bit4_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef BIT4_EXPAND_ERR_EN
  logic err;
`endif

  bit4_expand_if bus ();

  bit4_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BIT4_EXPAND_ERR_EN
    ,
    .err (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];   // {bit, last}
  int         cnt_q[$];   // expected ones per word
  bit         rdy_pat[$];
  bit         rdy_rand = 1'b0;
  int         ones = 0;
  int         hs_cnt = 0;
  int         acc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c);
    return (c > 4) ? 4 : c;
  endfunction

  // out_ready driver: directed pattern first, else random or held high
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_pat.size() != 0) bus.out_ready = rdy_pat.pop_front();
      else if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
      else bus.out_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every serial handshake, counts ones per word
  initial begin
    logic [1:0] e;
    int c;
    forever begin
      @(negedge clk);
      if (!rst && bus.in_valid && bus.in_ready) acc_cnt++;
      if (!rst && bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        chk("in_ready_during_shift", 32'(bus.in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got bit %0b with empty scoreboard", bus.out_bit);
        end else begin
          e = exp_q.pop_front();
          chk("out_bit", 32'(bus.out_bit), 32'(e[1]));
          chk("out_last", 32'(bus.out_last), 32'(e[0]));
          if (bus.out_bit) ones++;
          if (bus.out_last) begin
            c = (cnt_q.size() != 0) ? cnt_q.pop_front() : -1;
            chk("ones_per_word", 32'(ones), 32'(c));
            ones = 0;
          end
        end
      end
    end
  end

  // Wait for IDLE, present count c for one accept, push expectations, check word and latency
  task automatic send(input int c, input bit hold);
    int n = 0;
    while (!bus.in_ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 100) begin
        chk("send_timeout", 32'd1, 32'd0);
        return;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_count = 3'(c);
    for (int i = 0; i < 4; i++) exp_q.push_back({1'(i < sat(c)), 1'(i == 3)});
    cnt_q.push_back(sat(c));
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    chk("word_load", 32'(bus.word), 32'((1 << sat(c)) - 1));
    chk("first_valid_latency", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || !bus.in_ready) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        return;
      end
    end
  endtask

  initial begin
    int base_hs, base_acc, n;
    bus.in_valid = 1'b0;
    bus.in_count = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_word", 32'(bus.word), 32'd0);
    chk("rst_out_bit", 32'(bus.out_bit), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
`ifdef BIT4_EXPAND_ERR_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Count 3 with out_ready high: 4 cycles of output, in_ready back on cycle 5
    send(3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("c3_cycle4_in_ready", 32'(bus.in_ready), 32'd0);
    chk("c3_cycle4_last", 32'(bus.out_last), 32'd1);
    @(posedge clk);
    #1;
    chk("c3_cycle5_in_ready", 32'(bus.in_ready), 32'd1);
    drain();

    send(0, 1'b0);
    drain();
    send(4, 1'b0);
    drain();

    // Count 2 under a stalling consumer while in_valid stays high through SHIFT
    base_hs  = hs_cnt;
    base_acc = acc_cnt;
    send(2, 1'b1);
    rdy_pat = '{1, 0, 0, 1, 1, 0, 1};
    bus.in_count = 3'd4;
    repeat (6) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    chk("c2_handshakes", 32'(hs_cnt - base_hs), 32'd4);
    chk("c2_single_accept", 32'(acc_cnt - base_acc), 32'd1);

    // Saturating illegal count
    send(6, 1'b0);
`ifdef BIT4_EXPAND_ERR_EN
    chk("err_set", 32'(err), 32'd1);
`endif
    drain();
    send(1, 1'b0);
    drain();
`ifdef BIT4_EXPAND_ERR_EN
    chk("err_sticky", 32'(err), 32'd1);
`endif

    // Reset after the 2nd handshake of count 4
    base_hs = hs_cnt;
    send(4, 1'b0);
    n = 0;
    while (hs_cnt - base_hs < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_reset_reach", 32'(hs_cnt - base_hs), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    cnt_q.delete();
    ones = 0;
    chk("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_reset_word", 32'(bus.word), 32'd0);
`ifdef BIT4_EXPAND_ERR_EN
    chk("mid_reset_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    send(1, 1'b0);
    drain();

    // Random counts, random back-pressure
    rdy_rand = 1'b1;
    for (int k = 0; k < 25; k++) begin
      send(int'($urandom_range(0, 4)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rdy_rand = 1'b0;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
